// File: rtl/md5_core_arbiter.sv
// md5_core_arbiter
// Shares one pancham MD5 core between NUM_REQ brute-force candidate
// generators. Candidates are granted round-robin and issued to the core one at
// a time. Only one hash is ever in flight. Each digest is compared with
// target_hash. On a match, the block reports the winning requester and its
// plaintext, then stops until the next start.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   start                pulse: begin or restart a search (IDLE/FOUND only)
//   target_hash          digest being searched for
//   req_valid/word/width candidate inputs, one slot per requester
//   req_ready            one-hot grant, high only in the arbitration cycle
//   core_*               handshake to and from the pancham core
//   busy                 high in every state except IDLE and FOUND
//   found/found_id/plaintext  sticky match result
//   hashes_tried         digests compared since the last start, saturating
//
// Optional feature (macro ARB_HASH_TIMEOUT_EN):
//   Adds the output timeout_err. A digest that has not arrived after
//   TIMEOUT_CYCLES cycles in WAIT is abandoned, and arbitration resumes.
module md5_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [127:0]           target_hash,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_word,
    input  logic [NUM_REQ*8-1:0]   req_width,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [127:0]           core_word,
    output logic [7:0]             core_width,
    output logic                   core_valid,
    input  logic                   core_ready,
    input  logic [127:0]           core_hash,
    input  logic                   core_hash_valid,
    output logic                   busy,
    output logic                   found,
    output logic [ID_W-1:0]        found_id,
    output logic [127:0]           plaintext,
    output logic [31:0]            hashes_tried
`ifdef ARB_HASH_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_FOUND = 3'd5;

    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("md5_core_arbiter: parameter out of range");
    end

    logic [2:0]      state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [127:0]    word_q, word_d;
    logic [7:0]      width_q, width_d;
    logic [127:0]    hash_q, hash_d;
    logic            found_q, found_d;
    logic [ID_W-1:0] found_id_q, found_id_d;
    logic [127:0]    plaintext_q, plaintext_d;
    logic [31:0]     tried_q, tried_d;

`ifdef ARB_HASH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // Round-robin search. The search starts one past the last grant and wraps.
    // Because the first hit wins, the requester served last has the lowest
    // priority.
    logic [ID_W-1:0]    scan_idx;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [127:0]       sel_word;
    logic [7:0]         sel_width;

    always_comb begin
        scan_idx  = '0;
        gnt_id    = '0;
        gnt_any   = 1'b0;
        gnt_oh    = '0;
        sel_word  = '0;
        sel_width = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any          = 1'b1;
                gnt_id           = scan_idx;
                gnt_oh[scan_idx] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_word  = req_word[i*128 +: 128];
                sel_width = req_width[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gid_d       = gid_q;
        word_d      = word_q;
        width_d     = width_q;
        hash_d      = hash_q;
        found_d     = found_q;
        found_id_d  = found_id_q;
        plaintext_d = plaintext_q;
        tried_d     = tried_q;
`ifdef ARB_HASH_TIMEOUT_EN
        to_cnt_d      = '0;   // only counts while sitting in WAIT
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE, S_FOUND: begin
                if (start) begin
                    state_d = S_ARB;
                    tried_d = '0;
                    found_d = 1'b0;
`ifdef ARB_HASH_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            S_ARB: begin
                if (gnt_any) begin
                    word_d  = sel_word;
                    width_d = sel_width;
                    gid_d   = gnt_id;
                    rr_d    = gnt_id;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_hash_valid) begin
                    hash_d  = core_hash;
                    state_d = S_CHECK;
                end
`ifdef ARB_HASH_TIMEOUT_EN
                // Drop the candidate. rr already points past it, so the other
                // requesters get their turn before it is granted again.
                else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ARB;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_CHECK: begin
                if (tried_q != 32'hFFFF_FFFF) tried_d = tried_q + 32'd1;
                if (hash_q == target_hash) begin
                    found_d     = 1'b1;
                    found_id_d  = gid_q;
                    plaintext_d = word_q;
                    state_d     = S_FOUND;
                end else begin
                    state_d = S_ARB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= ID_W'(NUM_REQ - 1);
            gid_q       <= '0;
            word_q      <= '0;
            width_q     <= '0;
            hash_q      <= '0;
            found_q     <= 1'b0;
            found_id_q  <= '0;
            plaintext_q <= '0;
            tried_q     <= '0;
`ifdef ARB_HASH_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gid_q       <= gid_d;
            word_q      <= word_d;
            width_q     <= width_d;
            hash_q      <= hash_d;
            found_q     <= found_d;
            found_id_q  <= found_id_d;
            plaintext_q <= plaintext_d;
            tried_q     <= tried_d;
`ifdef ARB_HASH_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign req_ready    = (state_q == S_ARB) ? gnt_oh : '0;
    assign core_valid   = (state_q == S_ISSUE);
    assign core_word    = word_q;
    assign core_width   = width_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_FOUND);
    assign found        = found_q;
    assign found_id     = found_id_q;
    assign plaintext    = plaintext_q;
    assign hashes_tried = tried_q;
`ifdef ARB_HASH_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`endif

endmodule

// File: tb/tb_md5_core_arbiter.sv
// Self-checking bench for md5_core_arbiter (NUM_REQ=4). Inputs are driven just
// after the falling edge, and outputs are sampled 1 time unit later. A small
// reference model holds the round-robin pointer, the compare count and the
// match result.
module tb_md5_core_arbiter;

    localparam logic [127:0] TARGET = 128'h900150983cd24fb0d6963f7d28e17f72;

    logic         clock, reset, start;
    logic [127:0] target_hash;
    logic [3:0]   req_valid, req_ready;
    logic [511:0] req_word;
    logic [31:0]  req_width;
    logic [127:0] core_word, core_hash, plaintext;
    logic [7:0]   core_width;
    logic         core_valid, core_ready, core_hash_valid, busy, found;
    logic [1:0]   found_id;
    logic [31:0]  hashes_tried;
`ifdef ARB_HASH_TIMEOUT_EN
    logic         timeout_err;
`endif

    md5_core_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(10)) dut (
        .clock(clock), .reset(reset), .start(start), .target_hash(target_hash),
        .req_valid(req_valid), .req_word(req_word), .req_width(req_width),
        .req_ready(req_ready), .core_word(core_word), .core_width(core_width),
        .core_valid(core_valid), .core_ready(core_ready), .core_hash(core_hash),
        .core_hash_valid(core_hash_valid), .busy(busy), .found(found),
        .found_id(found_id), .plaintext(plaintext), .hashes_tried(hashes_tried)
`ifdef ARB_HASH_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int           m_rr;
    int unsigned  m_hashes;
    bit           m_found;
    int           m_id;
    logic [127:0] m_pt;

    typedef struct {
        logic [3:0] vmask;
        bit         match;
        int         rdly;
        int         hdly;
        bit         stray;
        int         exp_g;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Search from the pointer plus one with wrap-around. The first valid
    // requester wins.
    function automatic int model_next(input logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(m_rr + k) % 4]) return (m_rr + k) % 4;
        return -1;
    endfunction

    task automatic rand_words;
        for (int i = 0; i < 4; i++) begin
            req_word[i*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_width[i*8 +: 8]    = 8'($urandom());
        end
    endtask

    task automatic start_pulse;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        m_hashes = 0;
        m_found  = 1'b0;
        chk("start_found", found, 0);
        chk("start_tried", hashes_tried, 0);
        chk("start_busy", busy, 1);
`ifdef ARB_HASH_TIMEOUT_EN
        chk("start_timeout_err", timeout_err, 0);
`endif
    endtask

    task automatic hold_found(input int cycles);
        req_valid = 4'hF;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock); #1;
            chk("hold_found/ready/valid/busy", {found, req_ready, core_valid, busy}, {1'b1, 4'b0, 1'b0, 1'b0});
            chk("hold_found_id", found_id, 128'(m_id));
        end
    endtask

    // A full transaction: grant, issue with rdly stalled cycles, digest after
    // hdly WAIT cycles, then CHECK. With stray=1, the task also drives a
    // matching digest during ISSUE and a start pulse during WAIT. The DUT must
    // ignore both.
    task automatic do_round(input logic [3:0] vmask, input bit match, input int rdly,
                            input int hdly, input bit stray, input int exp_g);
        logic [127:0] w, dg;
        logic [7:0]   wd;
        logic [3:0]   eg;
        int           n;
        req_valid = vmask;
        w  = req_word[exp_g*128 +: 128];
        wd = req_width[exp_g*8 +: 8];
        eg = 4'b0001 << exp_g;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 50) begin
            @(negedge clock); #1;
            n++;
        end
        chk("grant", req_ready, eg);
        if (req_ready == 4'b0) return;
        @(negedge clock); #1;
        chk("issue_valid", core_valid, 1);
        chk("issue_word", core_word, w);
        chk("issue_width", core_width, wd);
        chk("issue_no_grant", req_ready, 0);
        for (int k = 0; k < rdly; k++) begin
            if (stray) begin
                core_hash_valid = 1'b1;
                core_hash = TARGET;
            end
            @(negedge clock);
            core_hash_valid = 1'b0;
            #1;
            chk("bp_valid", core_valid, 1);
            chk("bp_word", core_word, w);
        end
        core_ready = 1'b1;
        @(negedge clock);
        core_ready = 1'b0;
        #1;
        chk("wait_valid", core_valid, 0);
        chk("wait_busy", busy, 1);
        for (int k = 0; k < hdly; k++) begin
            if (stray && k == 0) start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            #1;
        end
        dg = match ? TARGET : (TARGET ^ {96'd0, $urandom() | 32'd1});
        core_hash = dg;
        core_hash_valid = 1'b1;
        @(negedge clock);
        core_hash_valid = 1'b0;
        core_hash = TARGET;
        #1;
        chk("check_busy", busy, 1);
        chk("check_found", found, 0);
        @(negedge clock); #1;
        m_rr = exp_g;
        if (m_hashes != 32'hFFFF_FFFF) m_hashes++;
        if (match) begin
            m_found = 1'b1;
            m_id    = exp_g;
            m_pt    = w;
        end
        chk("found", found, m_found);
        chk("hashes_tried", hashes_tried, m_hashes);
        chk("busy_after", busy, !m_found);
        if (m_found) begin
            chk("found_id", found_id, 128'(m_id));
            chk("plaintext", plaintext, m_pt);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int         n, g;
        logic [3:0] mask, eg;
        bit         mt;
        clock = 0; reset = 1; start = 0; target_hash = TARGET;
        req_valid = 0; req_word = '0; req_width = '0;
        core_ready = 0; core_hash = '0; core_hash_valid = 0;
        m_rr = 3; m_hashes = 0; m_found = 0; m_id = 0; m_pt = '0;

        tbl[0]  = '{4'hF, 1'b0, 0, 0, 1'b0, 3};
        tbl[1]  = '{4'hF, 1'b0, 1, 2, 1'b1, 0};
        tbl[2]  = '{4'hF, 1'b0, 0, 1, 1'b0, 1};
        tbl[3]  = '{4'hF, 1'b0, 2, 0, 1'b1, 2};
        tbl[4]  = '{4'hF, 1'b0, 0, 3, 1'b1, 3};
        tbl[5]  = '{4'hF, 1'b0, 1, 0, 1'b0, 0};
        tbl[6]  = '{4'hF, 1'b0, 0, 0, 1'b0, 1};
        tbl[7]  = '{4'hF, 1'b0, 3, 1, 1'b1, 2};
        tbl[8]  = '{4'hF, 1'b0, 5, 0, 1'b1, 3};
        tbl[9]  = '{4'b1010, 1'b0, 0, 0, 1'b0, 1};
        tbl[10] = '{4'b0001, 1'b0, 0, 2, 1'b0, 0};
        tbl[11] = '{4'b0110, 1'b1, 1, 1, 1'b0, 1};

        repeat (2) @(negedge clock);
        reset = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_found", found, 0);
        chk("rst_found_id", found_id, 0);
        chk("rst_plaintext", plaintext, 0);
        chk("rst_core_word", core_word, 0);
        chk("rst_core_width", core_width, 0);
        chk("rst_tried", hashes_tried, 0);
`ifdef ARB_HASH_TIMEOUT_EN
        chk("rst_timeout_err", timeout_err, 0);
`endif
        // A digest in IDLE is ignored.
        core_hash_valid = 1; core_hash = TARGET;
        @(negedge clock);
        core_hash_valid = 0;
        #1;
        chk("idle_stray_busy", busy, 0);
        chk("idle_stray_found", found, 0);

        // Single requester: "abc" on requester 2 matches.
        start_pulse();
        rand_words();
        req_word[2*128 +: 128] = 128'h616263;
        req_width[2*8 +: 8]    = 8'd3;
        do_round(4'b0100, 1'b1, 1, 2, 1'b0, 2);
        hold_found(20);
        start_pulse();

        // Table: round-robin rotation, backpressure, skipped requesters, match.
        for (int i = 0; i < 12; i++) begin
            rand_words();
            do_round(tbl[i].vmask, tbl[i].match, tbl[i].rdly, tbl[i].hdly, tbl[i].stray, tbl[i].exp_g);
            if (i == 7) chk("tried_after_8", hashes_tried, 8);
        end
        hold_found(20);
        start_pulse();
        rand_words();
        do_round(4'hF, 1'b0, 0, 0, 1'b0, 2);

        // Randomized rounds checked against the model.
        for (int r = 0; r < 30; r++) begin
            rand_words();
            mask = 4'($urandom_range(1, 15));
            mt   = ($urandom_range(0, 5) == 0);
            do_round(mask, mt, $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), model_next(mask));
            if (mt) start_pulse();
        end

        // Reset in the middle of WAIT. A late digest is ignored afterwards.
        rand_words();
        req_valid = 4'hF;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 50) begin
            @(negedge clock); #1;
            n++;
        end
        @(negedge clock); #1;
        core_ready = 1;
        @(negedge clock);
        core_ready = 0;
        #1;
        chk("pre_rst_wait_busy", busy, 1);
        reset = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_core_valid", core_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_found", found, 0);
        chk("midrst_tried", hashes_tried, 0);
        @(negedge clock);
        reset = 0;
        core_hash_valid = 1; core_hash = TARGET;
        @(negedge clock);
        core_hash_valid = 0;
        #1;
        chk("post_rst_stray_busy", busy, 0);
        chk("post_rst_stray_found", found, 0);
        m_rr = 3; m_hashes = 0; m_found = 0;
        start_pulse();
        rand_words();
        do_round(4'hF, 1'b0, 0, 0, 1'b0, model_next(4'hF));

`ifdef ARB_HASH_TIMEOUT_EN
        // The core never answers. The candidate is dropped after 10 WAIT cycles.
        rand_words();
        req_valid = 4'hF;
        #1;
        g = model_next(4'hF);
        eg = 4'b0001 << g;
        chk("to_grant", req_ready, eg);
        m_rr = g;
        @(negedge clock); #1;
        core_ready = 1;
        @(negedge clock);
        core_ready = 0;
        #1;
        n = 0;
        while (!timeout_err && n < 40) begin
            n++;
            @(negedge clock); #1;
        end
        chk("timeout_wait_cycles", n, 10);
        chk("timeout_err", timeout_err, 1);
        chk("timeout_tried", hashes_tried, m_hashes);
        eg = 4'b0001 << model_next(4'hF);
        chk("timeout_next_grant", req_ready, eg);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
